debounced_edge_detector: RTL

Multi-channel input conditioner and edge detector for asynchronous button/switch inputs. Each channel is synchronised, debounced by a programmable stable-count filter, and converted to single-cycle rise/fall pulses plus a mode-selected event pulse and a sticky pending flag with per-channel clear. It sits between board-level inputs and the control FSMs, replacing per-input single-bit rising-edge detectors.

---
 rtl/debounced_edge_detector_if.sv | 51 +++++
 rtl/debounced_edge_detector.sv | 134 +++++++++++++
 2 files changed

// File: rtl/debounced_edge_detector_if.sv
// Purpose : bundles the per-channel input/output vectors of debounced_edge_detector.
// Latency : none (wires only).
// Backpressure: none; all signals are level/pulse, no handshake.
//
// Ports (as seen by the detector through the slave modport):
//   signal  [CHANNELS-1:0] in   raw asynchronous inputs
//   mode    [1:0]          in   event select: 00 rise, 01 fall, 10 both, 11 off
//   clear   [CHANNELS-1:0] in   per-channel synchronous clear of pending
//   level   [CHANNELS-1:0] out  debounced level
//   rise    [CHANNELS-1:0] out  one-cycle pulse on debounced 0->1
//   fall    [CHANNELS-1:0] out  one-cycle pulse on debounced 1->0
//   outedge [CHANNELS-1:0] out  one-cycle pulse when the edge matches mode
//   pending [CHANNELS-1:0] out  sticky event flag
interface debounced_edge_detector_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] signal;
  logic [1:0]          mode;
  logic [CHANNELS-1:0] clear;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] outedge;
  logic [CHANNELS-1:0] pending;

  // Driver side: board inputs and control, observes conditioned outputs.
  modport master (
    output signal,
    output mode,
    output clear,
    input  level,
    input  rise,
    input  fall,
    input  outedge,
    input  pending
  );

  // Detector side.
  modport slave (
    input  signal,
    input  mode,
    input  clear,
    output level,
    output rise,
    output fall,
    output outedge,
    output pending
  );

endinterface

// File: rtl/debounced_edge_detector.sv
// Purpose : multi-channel synchroniser + stable-count debouncer + rise/fall/event/pending generator.
// Latency : input sampled at edge 0 -> level/rise/fall/outedge/pending change after edge SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; pulses are single-cycle, pending holds an event until cleared.
//
// Ports:
//   clk    in   single clock, all state on posedge
//   reset  in   asynchronous active-high reset, clears every register immediately
//   bus    slave modport of debounced_edge_detector_if (signal/mode/clear in,
//               level/rise/fall/outedge/pending out)
//
// Per channel the raw input is first captured by a sample flop (edge 0) and then
// passes SYNC_STAGES synchroniser flops; the last of these is sync_out. The
// debouncer counts consecutive cycles in which sync_out disagrees with level and
// accepts the new level on the DEBOUNCE_CYCLES-th such cycle.
module debounced_edge_detector #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic                     clk,
  input logic                     reset,
  debounced_edge_detector_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // Terminal count: the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  // sync_q[i][0] is the input sample flop, sync_q[i][SYNC_STAGES] is sync_out.
  logic [SYNC_STAGES:0] sync_q  [CHANNELS];
  logic [CNT_W-1:0]     cnt_q   [CHANNELS];
  logic [CHANNELS-1:0]  level_q;
  logic [CHANNELS-1:0]  rise_q;
  logic [CHANNELS-1:0]  fall_q;
  logic [CHANNELS-1:0]  outedge_q;
  logic [CHANNELS-1:0]  pending_q;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  logic [CHANNELS-1:0]  sync_out;
  logic [CHANNELS-1:0]  accept;     // level flips at this edge
  logic [CNT_W-1:0]     cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]  rise_d;
  logic [CHANNELS-1:0]  fall_d;
  logic [CHANNELS-1:0]  outedge_d;
  logic [CHANNELS-1:0]  pending_d;
  mode_e                mode_sel;

  assign mode_sel = mode_e'(bus.mode);

  always_comb begin
    sync_out = '0;
    accept   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]    = '0;
      sync_out[i] = sync_q[i][SYNC_STAGES];

      if (sync_out[i] == level_q[i]) begin
        // Agreement (including a glitch returning early) discards any partial count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        accept[i] = 1'b1;
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    // On acceptance the new level is sync_out, so its value names the edge direction.
    rise_d = accept & sync_out;
    fall_d = accept & ~sync_out;

    // mode is taken at the edge where level flips.
    outedge_d = '0;
    case (mode_sel)
      MODE_RISE: outedge_d = rise_d;
      MODE_FALL: outedge_d = fall_d;
      MODE_BOTH: outedge_d = rise_d | fall_d;
      MODE_OFF:  outedge_d = '0;
      default:   outedge_d = '0;
    endcase

    // A new event wins over a simultaneous clear so no event is lost.
    pending_d = outedge_d | (pending_q & ~bus.clear);
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      outedge_q <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-1:0], bus.signal[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      level_q   <= level_q ^ accept;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      outedge_q <= outedge_d;
      pending_q <= pending_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.level   = level_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.outedge = outedge_q;
  assign bus.pending = pending_q;

endmodule
